// File: rtl/key_event_scheduler.sv
// Buffers one press/depress event per key and round-robins them onto a single UART byte stream.
// Optional auto-repeat of held keys is compiled in with `define KEY_EVT_REPEAT_EN.
module key_event_scheduler #(
  parameter int unsigned N             = 4,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000,
  parameter int unsigned REP_W         = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] press,
  input  logic [N-1:0] depress,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [N-1:0] held,
  output logic [7:0]   overrun_cnt
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, grant_q, grant_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    overrun_q, overrun_d;
  logic [N-1:0]  held_q, held_d;
  logic [N-1:0]  slot_valid_q, slot_valid_d;
  logic [N-1:0]  slot_press_q, slot_press_d;
  logic [N-1:0]  slot_rep_q, slot_rep_d;
  logic [N-1:0]  clear, can_store, rep_fire;
  logic          found;
  logic [IW-1:0] pick;
  logic [6:0]    drops;
  logic [8:0]    ovr_sum;

  // First valid slot at or above rr, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < int'(N); k++) begin
      int j;
      j = int'(rr_q) + k;
      if (j >= int'(N)) j = j - int'(N);
      if (!found && slot_valid_q[IW'(j)]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    clear     = '0;
    case (state_q)
      StIdle: begin
        if (found) begin
          clear[pick] = 1'b1;
          tx_data_d   = {slot_press_q[pick], slot_rep_q[pick], 6'(pick)};
          grant_d     = pick;
          state_d     = StPresent;
        end
      end
      StPresent: begin
        if (tx_ready) begin
          rr_d    = (grant_q == IW'(N - 1)) ? '0 : grant_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A slot being granted this cycle may be refilled in the same cycle.
  assign can_store = ~slot_valid_q | clear;

  always_comb begin
    slot_valid_d = slot_valid_q & ~clear;
    slot_press_d = slot_press_q;
    slot_rep_d   = slot_rep_q;
    held_d       = held_q;
    drops        = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (press[i]) held_d[i] = 1'b1;
      else if (depress[i]) held_d[i] = 1'b0;
      if ((press[i] || depress[i]) && (!can_store[i] || (press[i] && depress[i]))) begin
        drops = drops + 7'd1;
      end
      if ((press[i] || depress[i] || rep_fire[i]) && can_store[i]) begin
        slot_valid_d[i] = 1'b1;
        slot_press_d[i] = press[i] || !depress[i];
        slot_rep_d[i]   = !press[i] && !depress[i];
      end
    end
  end

  assign ovr_sum   = {1'b0, overrun_q} + {2'b00, drops};
  assign overrun_d = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];

`ifdef KEY_EVT_REPEAT_EN
  logic [REP_W-1:0] rep_cnt_q [N];
  logic [REP_W-1:0] rep_cnt_d [N];

  // Counter reads k-1 in the k-th cycle after the press; reload keeps later fires PERIOD apart.
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < int'(N); i++) begin
      rep_cnt_d[i] = rep_cnt_q[i];
      if (press[i] || depress[i]) begin
        rep_cnt_d[i] = '0;
      end else if (held_q[i]) begin
        if (rep_cnt_q[i] == REP_W'(REPEAT_DELAY - 1)) begin
          rep_fire[i]  = 1'b1;
          rep_cnt_d[i] = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) rep_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) rep_cnt_q[i] <= rep_cnt_d[i];
    end
  end
`else
  logic unused_rep_cfg;
  assign unused_rep_cfg = (REPEAT_DELAY != REPEAT_PERIOD) ^ (REP_W != 0);
  assign rep_fire       = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_q         <= '0;
      grant_q      <= '0;
      tx_data_q    <= '0;
      overrun_q    <= '0;
      held_q       <= '0;
      slot_valid_q <= '0;
      slot_press_q <= '0;
      slot_rep_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      grant_q      <= grant_d;
      tx_data_q    <= tx_data_d;
      overrun_q    <= overrun_d;
      held_q       <= held_d;
      slot_valid_q <= slot_valid_d;
      slot_press_q <= slot_press_d;
      slot_rep_q   <= slot_rep_d;
    end
  end

  assign tx_valid    = (state_q == StPresent);
  assign tx_data     = tx_data_q;
  assign held        = held_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler (N = 4, short repeat timing).
module tb_key_event_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] press = '0;
  logic [3:0] depress = '0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [3:0] held;
  logic [7:0] overrun_cnt;

  int tests = 0;
  int fails = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  key_event_scheduler #(
    .N(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(10), .REP_W(26)
  ) dut (
    .clk(clk), .rst_n(rst_n), .press(press), .depress(depress),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .held(held), .overrun_cnt(overrun_cnt)
  );

  // Handshake capture mid-cycle; values here are the ones seen at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) got.push_back(tx_data);
  end

  typedef struct packed {
    logic [3:0]      p;
    logic [3:0]      d;
    logic [2:0]      n;
    logic [3:0][7:0] exp;
    logic [3:0]      held;
    logic [7:0]      ovr;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_bytes(input string name);
    check({name, " count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check($sformatf("%s byte%0d", name, i), {24'h0, got[i]}, {24'h0, exp_q[i]});
    end
  endtask

  task automatic do_reset();
    press   = '0;
    depress = '0;
    rst_n   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    got.delete();
  endtask

  task automatic pulse(input logic [3:0] p, input logic [3:0] d);
    press   = p;
    depress = d;
    tick();
    press   = '0;
    depress = '0;
  endtask

  initial begin
    logic [7:0] exp_data [7];
    logic       exp_valid [7];

    vecs[0] = '{p: 4'b0100, d: 4'b0000, n: 3'd1, exp: {8'h00, 8'h00, 8'h00, 8'h82},
                held: 4'b0100, ovr: 8'd0};
    vecs[1] = '{p: 4'b1011, d: 4'b0000, n: 3'd3, exp: {8'h00, 8'h83, 8'h81, 8'h80},
                held: 4'b1011, ovr: 8'd0};
    vecs[2] = '{p: 4'b0000, d: 4'b0001, n: 3'd1, exp: {8'h00, 8'h00, 8'h00, 8'h00},
                held: 4'b0000, ovr: 8'd0};
    vecs[3] = '{p: 4'b0010, d: 4'b0010, n: 3'd1, exp: {8'h00, 8'h00, 8'h00, 8'h81},
                held: 4'b0010, ovr: 8'd1};
    vecs[4] = '{p: 4'b1111, d: 4'b1111, n: 3'd4, exp: {8'h83, 8'h82, 8'h81, 8'h80},
                held: 4'b1111, ovr: 8'd4};
    vecs[5] = '{p: 4'b0000, d: 4'b1100, n: 3'd2, exp: {8'h00, 8'h00, 8'h03, 8'h02},
                held: 4'b0000, ovr: 8'd0};

    // Reset state
    rst_n = 1'b0;
    tick();
    check("reset tx_valid", {31'h0, tx_valid}, 32'h0);
    check("reset tx_data", {24'h0, tx_data}, 32'h0);
    check("reset held", {28'h0, held}, 32'h0);
    check("reset overrun", {24'h0, overrun_cnt}, 32'h0);

    // Single-cycle pulse vectors, each from reset with tx_ready high
    for (int v = 0; v < 6; v++) begin
      do_reset();
      tx_ready = 1'b1;
      pulse(vecs[v].p, vecs[v].d);
      repeat (12) tick();
      exp_q.delete();
      for (int b = 0; b < int'(vecs[v].n); b++) exp_q.push_back(vecs[v].exp[b]);
      check_bytes($sformatf("vec%0d", v));
      check($sformatf("vec%0d held", v), {28'h0, held}, {28'h0, vecs[v].held});
      check($sformatf("vec%0d overrun", v), {24'h0, overrun_cnt}, {24'h0, vecs[v].ovr});
    end

    // Two-cycle latency and single-cycle valid for one event
    do_reset();
    tx_ready = 1'b1;
    pulse(4'b0100, 4'b0000);
    check("lat t+1 valid", {31'h0, tx_valid}, 32'h0);
    tick();
    check("lat t+2 valid", {31'h0, tx_valid}, 32'h1);
    check("lat t+2 data", {24'h0, tx_data}, 32'h82);
    tick();
    check("lat t+3 valid", {31'h0, tx_valid}, 32'h0);

    // Back-to-back bytes separated by exactly one idle cycle
    do_reset();
    tx_ready = 1'b1;
    exp_valid = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_data  = '{8'h00, 8'h80, 8'h00, 8'h81, 8'h00, 8'h83, 8'h00};
    pulse(4'b1011, 4'b0000);
    for (int c = 0; c < 7; c++) begin
      check($sformatf("gap c%0d valid", c), {31'h0, tx_valid}, {31'h0, exp_valid[c]});
      if (exp_valid[c]) check($sformatf("gap c%0d data", c), {24'h0, tx_data}, {24'h0, exp_data[c]});
      tick();
    end

    // Round-robin wrap after granting key 3
    do_reset();
    tx_ready = 1'b0;
    pulse(4'b1000, 4'b0000);
    tick();
    pulse(4'b1001, 4'b0000);
    tick();
    tx_ready = 1'b1;
    repeat (10) tick();
    exp_q = '{8'h83, 8'h80, 8'h83};
    check_bytes("rr wrap");

    // Overrun while stalled: press, depress, press on key 1
    do_reset();
    tx_ready = 1'b0;
    pulse(4'b0010, 4'b0000);
    tick();
    tick();
    pulse(4'b0000, 4'b0010);
    pulse(4'b0010, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("stall c%0d valid", c), {31'h0, tx_valid}, 32'h1);
      check($sformatf("stall c%0d data", c), {24'h0, tx_data}, 32'h81);
      tick();
    end
    check("stall overrun", {24'h0, overrun_cnt}, 32'h1);
    tx_ready = 1'b1;
    repeat (8) tick();
    exp_q = '{8'h81, 8'h01};
    check_bytes("stall drain");
    check("stall held", {28'h0, held}, 32'h2);

    // Asynchronous reset while presenting with two slots pending
    do_reset();
    tx_ready = 1'b0;
    pulse(4'b0111, 4'b0000);
    tick();
    pulse(4'b0010, 4'b0000);
    tick();
    check("pre-rst valid", {31'h0, tx_valid}, 32'h1);
    check("pre-rst overrun", {24'h0, overrun_cnt}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst valid", {31'h0, tx_valid}, 32'h0);
    check("rst overrun", {24'h0, overrun_cnt}, 32'h0);
    check("rst held", {28'h0, held}, 32'h0);
    tick();
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    got.delete();
    repeat (10) tick();
    exp_q.delete();
    check_bytes("post-rst idle");
    pulse(4'b1000, 4'b0000);
    repeat (6) tick();
    exp_q = '{8'h83};
    check_bytes("post-rst new");

    // Key 0 held for 45 cycles
    do_reset();
    tx_ready = 1'b1;
    pulse(4'b0001, 4'b0000);
    repeat (44) tick();
    pulse(4'b0000, 4'b0001);
    repeat (10) tick();
`ifdef KEY_EVT_REPEAT_EN
    exp_q = '{8'h80, 8'hC0, 8'hC0, 8'hC0, 8'h00};
`else
    exp_q = '{8'h80, 8'h00};
`endif
    check_bytes("repeat");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
